sim_run_ctrl: RTL and testbench

Parametrised run controller for the single-cycle MIPS simulation benches. It sequences reset and run phases for one or more `mips` cores and budgets the run by cycle count. It watches each core's PC and halt flag, ends the run on all-halted, PC stall or timeout, and reports the cause. The bench instantiates it between its clock source and the cores, in place of hand-written `#delay` reset/finish sequences.

---
 rtl/sim_run_pkg.sv | 29 ++
 rtl/sim_run_ctrl_if.sv | 42 ++++
 rtl/sim_stall_mon.sv | 57 +++++
 rtl/sim_run_ctrl.sv | 150 +++++++++++++++
 tb/tb_sim_run_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sim_run_pkg.sv
// -----------------------------------------------------------------------------
// sim_run_pkg
// Shared types for the MIPS bench run controller:
//   run_state_e  - controller FSM states
//   end_cause_e  - why a run ended (none / all halted / PC stall / budget)
//   cnt_width()  - bits needed for a counter that spans 0..n-1 (min 1)
// -----------------------------------------------------------------------------
package sim_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RESET_HOLD = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        END_NONE    = 2'd0,
        END_HALT    = 2'd1,
        END_STALL   = 2'd2,
        END_TIMEOUT = 2'd3
    } end_cause_e;

    // Width of a counter that must hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// sim_run_ctrl_if
// Bundle between the bench (master) and the run controller (slave).
//   start      master->slave  level request to begin a run
//   core_pc    master->slave  packed PCs, core i at [i*PC_W +: PC_W]
//   core_halt  master->slave  per-core halt flag
//   core_reset slave->master  active-high reset to each core
//   core_en    slave->master  core clock enable (RUN only)
//   running    slave->master  controller is in RUN
//   done       slave->master  controller is in DONE
//   timeout    slave->master  run ended on cycle budget
//   stall_err  slave->master  per-core stall flag
//   cycle_cnt  slave->master  RUN cycles elapsed
// -----------------------------------------------------------------------------
interface sim_run_ctrl_if #(
    parameter int NUM_CORES = 1,
    parameter int PC_W      = 32,
    parameter int CNT_W     = 32
) ();

    logic                      start;
    logic [NUM_CORES*PC_W-1:0] core_pc;
    logic [NUM_CORES-1:0]      core_halt;
    logic [NUM_CORES-1:0]      core_reset;
    logic                      core_en;
    logic                      running;
    logic                      done;
    logic                      timeout;
    logic [NUM_CORES-1:0]      stall_err;
    logic [CNT_W-1:0]          cycle_cnt;

    modport master (
        output start, core_pc, core_halt,
        input  core_reset, core_en, running, done, timeout, stall_err, cycle_cnt
    );

    modport slave (
        input  start, core_pc, core_halt,
        output core_reset, core_en, running, done, timeout, stall_err, cycle_cnt
    );

endinterface

// File: rtl/sim_stall_mon.sv
// -----------------------------------------------------------------------------
// sim_stall_mon
// Per-core PC stall detector. Remembers last cycle's PC and counts consecutive
// cycles on which the PC did not change.
//   clk, reset  clock / asynchronous active-low reset
//   clear       reload previous PC from pc and zero the counter
//   en          controller is in RUN
//   halt        core is halted; counter held at 0
//   pc          current core PC
//   stall_hit   pulse: this sample completes STALL_LIMIT equal PC samples
// -----------------------------------------------------------------------------
module sim_stall_mon
    import sim_run_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    input  logic            halt,
    input  logic [PC_W-1:0] pc,
    output logic            stall_hit
);

    localparam int              SC_W    = cnt_width(STALL_LIMIT);
    // The counter sits at STALL_LIMIT-2 after STALL_LIMIT-1 equal samples, so an
    // equal PC now is the STALL_LIMIT-th one and the counter would reach LIMIT-1.
    localparam logic [SC_W-1:0] HIT_AT  = SC_W'(STALL_LIMIT - 2);
    localparam logic [SC_W-1:0] CNT_TOP = SC_W'(STALL_LIMIT - 1);

    logic [PC_W-1:0] prev_pc_q;
    logic [SC_W-1:0] stall_cnt_q;
    logic            pc_same;

    assign pc_same   = (pc == prev_pc_q);
    assign stall_hit = en && !clear && !halt && pc_same && (stall_cnt_q == HIT_AT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_q   <= '0;
            stall_cnt_q <= '0;
        end else if (clear) begin
            prev_pc_q   <= pc;
            stall_cnt_q <= '0;
        end else if (en) begin
            prev_pc_q <= pc;
            if (halt || !pc_same) begin
                stall_cnt_q <= '0;
            end else if (stall_cnt_q != CNT_TOP) begin
                stall_cnt_q <= stall_cnt_q + SC_W'(1);
            end
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// sim_run_ctrl
// Run controller for single-cycle MIPS benches: holds the cores in reset for
// RESET_CYCLES, runs them for up to RUN_CYCLES, and stops on all-halted, PC
// stall or budget exhaustion, reporting the cause. All outputs are registered.
//   clk    bench clock, rising edge
//   reset  asynchronous active-low controller reset
//   bus    sim_run_ctrl_if slave: start/core_pc/core_halt in;
//          core_reset/core_en/running/done/timeout/stall_err/cycle_cnt out
// -----------------------------------------------------------------------------
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int NUM_CORES    = 1,
    parameter int PC_W         = 32,
    parameter int RESET_CYCLES = 5,
    parameter int RUN_CYCLES   = 100,
    parameter int STALL_LIMIT  = 16,
    parameter int STOP_ON_HALT = 1,
    parameter int CNT_W        = 32
) (
    input  logic           clk,
    input  logic           reset,
    sim_run_ctrl_if.slave  bus
);

    localparam int               HOLD_W    = cnt_width(RESET_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    run_state_e           state_q;
    logic [HOLD_W-1:0]    hold_q;
    logic [NUM_CORES-1:0] core_reset_q;
    logic                 core_en_q;
    logic                 running_q;
    logic                 done_q;
    logic                 timeout_q;
    logic [NUM_CORES-1:0] stall_err_q;
    logic [CNT_W-1:0]     cycle_cnt_q;

    logic                 run_active;
    logic                 mon_clear;
    logic [NUM_CORES-1:0] stall_hit;
    end_cause_e           end_cause_d;
    logic [CNT_W-1:0]     cycle_cnt_d;

    assign run_active = (state_q == ST_RUN);
    // cycle_cnt is zeroed on entry to RESET_HOLD and saturates rather than
    // wrapping, so a zero count inside RUN marks exactly the first RUN cycle.
    assign mon_clear  = !run_active || (cycle_cnt_q == '0);

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_mon
        sim_stall_mon #(
            .PC_W       (PC_W),
            .STALL_LIMIT(STALL_LIMIT)
        ) u_mon (
            .clk      (clk),
            .reset    (reset),
            .clear    (mon_clear),
            .en       (run_active),
            .halt     (bus.core_halt[gi]),
            .pc       (bus.core_pc[gi*PC_W +: PC_W]),
            .stall_hit(stall_hit[gi])
        );
    end

    assign cycle_cnt_d = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);

    // Only the highest-priority cause is reported when several coincide.
    always_comb begin
        end_cause_d = END_NONE;
        if (run_active) begin
            if ((STOP_ON_HALT != 0) && (&bus.core_halt)) begin
                end_cause_d = END_HALT;
            end else if (|stall_hit) begin
                end_cause_d = END_STALL;
            end else if (cycle_cnt_q == RUN_LAST) begin
                end_cause_d = END_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            core_reset_q <= '1;
            core_en_q    <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            stall_err_q  <= '0;
            cycle_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q      <= ST_RESET_HOLD;
                        hold_q       <= '0;
                        core_reset_q <= '1;
                        core_en_q    <= 1'b0;
                        running_q    <= 1'b0;
                        done_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        stall_err_q  <= '0;
                        cycle_cnt_q  <= '0;
                    end
                end
                ST_RESET_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q      <= ST_RUN;
                        core_reset_q <= '0;
                        core_en_q    <= 1'b1;
                        running_q    <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    if (end_cause_d != END_NONE) begin
                        state_q   <= ST_DONE;
                        core_en_q <= 1'b0;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (end_cause_d == END_STALL) begin
                            stall_err_q <= stall_hit;
                        end
                        if (end_cause_d == END_TIMEOUT) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.core_reset = core_reset_q;
    assign bus.core_en    = core_en_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.stall_err  = stall_err_q;
    assign bus.cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_run_ctrl
// Bench for sim_run_ctrl with two cores, RESET_CYCLES=5, RUN_CYCLES=20,
// STALL_LIMIT=4. Each table row describes per-core halt/freeze cycles and the
// expected run outcome; rows are queued when the run starts and checked when
// done rises.
// -----------------------------------------------------------------------------
module tb_sim_run_ctrl;

    localparam int NC    = 2;
    localparam int RC    = 5;
    localparam int RUNC  = 20;
    localparam int SL    = 4;
    localparam int CW    = 8;
    localparam int NEVER = 1000;
    localparam logic [31:0] BASE0 = 32'h0000_1000;
    localparam logic [31:0] BASE1 = 32'h0000_2FF8;  // reaches 0x3010 at cycle 6

    typedef struct {
        string      name;
        int         halt0;
        int         halt1;
        int         frz0;
        int         frz1;
        int         abort_at;
        int         exp_end;
        int         exp_cnt;
        logic       exp_to;
        logic [1:0] exp_stall;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    vec_t vecs[$];
    vec_t sb[$];

    sim_run_ctrl_if #(.NUM_CORES(NC), .PC_W(32), .CNT_W(CW)) bus ();

    sim_run_ctrl #(
        .NUM_CORES   (NC),
        .PC_W        (32),
        .RESET_CYCLES(RC),
        .RUN_CYCLES  (RUNC),
        .STALL_LIMIT (SL),
        .STOP_ON_HALT(1),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int h0, input int h1, input int f0,
                                input int f1, input int ab, input int e_end, input int e_cnt,
                                input logic e_to, input logic [1:0] e_st);
        vec_t v;
        v.name = nm; v.halt0 = h0; v.halt1 = h1; v.frz0 = f0; v.frz1 = f1;
        v.abort_at = ab; v.exp_end = e_end; v.exp_cnt = e_cnt;
        v.exp_to = e_to; v.exp_stall = e_st;
        return v;
    endfunction

    function automatic logic [31:0] pc_at(input logic [31:0] base, input int frz, input int n);
        int m;
        m = (n < frz) ? n : frz;
        return base + 32'(4 * m);
    endfunction

    task automatic drive(input vec_t v, input int n);
        bus.core_pc   = {pc_at(BASE1, v.frz1, n), pc_at(BASE0, v.frz0, n)};
        bus.core_halt = {(n >= v.halt1), (n >= v.halt0)};
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        bit   got;
        bit   aborted;
        got = 1'b0;
        aborted = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        drive(v, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("start_core_reset", 32'(bus.core_reset), 32'h3);
        chk("start_done_clr", 32'(bus.done), 32'h0);
        chk("start_timeout_clr", 32'(bus.timeout), 32'h0);
        chk("start_stall_clr", 32'(bus.stall_err), 32'h0);
        chk("start_cnt_clr", 32'(bus.cycle_cnt), 32'h0);
        for (int h = 1; h < RC; h++) begin
            @(posedge clk);
            #1;
            chk("hold_en_rst", 32'({bus.core_en, bus.core_reset}), 32'h3);
        end
        @(posedge clk);
        #1;
        chk("run_entry", 32'({bus.running, bus.core_en, bus.core_reset}), 32'hC);
        sb.push_back(v);
        for (int n = 0; n < 40 && !got && !aborted; n++) begin
            @(negedge clk);
            drive(v, n);
            if (n == v.abort_at) begin
                chk("pre_abort_cnt", 32'(bus.cycle_cnt), 32'(n));
                #2 reset = 1'b0;
                #1;
                chk("abort_core_reset", 32'(bus.core_reset), 32'h3);
                chk("abort_cnt", 32'(bus.cycle_cnt), 32'h0);
                chk("abort_flags", 32'({bus.running, bus.core_en, bus.done, bus.timeout}), 32'h0);
                e = sb.pop_front();
                repeat (2) @(negedge clk);
                reset = 1'b1;
                aborted = 1'b1;
                $display("run %s: aborted by reset at cycle %0d", v.name, n);
            end else begin
                @(posedge clk);
                #1;
                if (bus.done === 1'b1) begin
                    got = 1'b1;
                    e = sb.pop_front();
                    chk("end_cycle", 32'(n), 32'(e.exp_end));
                    chk("end_cnt", 32'(bus.cycle_cnt), 32'(e.exp_cnt));
                    chk("end_timeout", 32'(bus.timeout), 32'(e.exp_to));
                    chk("end_stall", 32'(bus.stall_err), 32'(e.exp_stall));
                    chk("end_idle_cores", 32'({bus.running, bus.core_en, bus.core_reset}), 32'h0);
                    $display("run %s: done at cycle %0d cnt=%0d timeout=%0b stall=%b",
                             v.name, n, bus.cycle_cnt, bus.timeout, bus.stall_err);
                end else begin
                    chk("run_busy", 32'({bus.running, bus.core_en, bus.done}), 32'h6);
                end
            end
        end
        if (!got && !aborted) begin
            chk("run_bound_done", 32'h0, 32'h1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.core_pc = '0;
        bus.core_halt = '0;

        //           name             h0     h1     f0     f1     abort  end cnt  to    stall
        vecs.push_back(mk("timeout",   NEVER, NEVER, NEVER, NEVER, -1,   19, 20, 1'b1, 2'b00));
        vecs.push_back(mk("halt_both", 7,     12,    7,     12,    -1,   12, 13, 1'b0, 2'b00));
        vecs.push_back(mk("stall_c1",  NEVER, NEVER, NEVER, 6,     -1,    9, 10, 1'b0, 2'b10));
        vecs.push_back(mk("part_halt", 2,     NEVER, 2,     NEVER, -1,   19, 20, 1'b1, 2'b00));
        vecs.push_back(mk("halt_last", 19,    19,    NEVER, NEVER, -1,   19, 20, 1'b0, 2'b00));
        vecs.push_back(mk("stall_both",NEVER, NEVER, 3,     3,     -1,    6,  7, 1'b0, 2'b11));
        vecs.push_back(mk("stall_last",NEVER, NEVER, 16,    NEVER, -1,   19, 20, 1'b0, 2'b01));
        vecs.push_back(mk("stall_c0_0",NEVER, NEVER, 0,     NEVER, -1,    3,  4, 1'b0, 2'b01));
        vecs.push_back(mk("halt_stall",5,     13,    5,     10,    -1,   13, 14, 1'b0, 2'b00));
        vecs.push_back(mk("abort9",    NEVER, NEVER, NEVER, NEVER, 9,     0,  0, 1'b0, 2'b00));
        vecs.push_back(mk("rerun",     NEVER, NEVER, NEVER, NEVER, -1,   19, 20, 1'b1, 2'b00));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_reset", 32'(bus.core_reset), 32'h3);
        chk("rst_outputs", 32'({bus.core_en, bus.running, bus.done, bus.timeout}), 32'h0);
        chk("rst_stall", 32'(bus.stall_err), 32'h0);
        chk("rst_cnt", 32'(bus.cycle_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        // IDLE without start must stay idle
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold", 32'({bus.core_en, bus.running, bus.done, bus.core_reset}), 32'h3);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
